// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: state encodings and mode constants.
package interval_timer_ctrl_pkg;

   localparam logic [1:0] TMR_IDLE = 2'd0;
   localparam logic [1:0] TMR_LOAD = 2'd1;
   localparam logic [1:0] TMR_RUN  = 2'd2;

   localparam logic TMR_ONESHOT  = 1'b0;
   localparam logic TMR_PERIODIC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = TMR_IDLE,
      ST_LOAD = TMR_LOAD,
      ST_RUN  = TMR_RUN
   } tmr_state_e;

endpackage

// File: rtl/interval_timer_ctrl_counter.sv
// Loadable up/down counter: sclr > load > enable; up_down=1 decrements, carry_out flags wrap/borrow.
module interval_timer_ctrl_counter #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         sclr,
   input  logic         load,
   input  logic         enable,
   input  logic         up_down,
   input  logic [n-1:0] data,
   output logic [n-1:0] count,
   output logic         carry_out
);

   logic [n-1:0] r_count;
   logic         r_carry;

   always_ff @(posedge clk) begin
      if (sclr) begin
         r_count <= '0;
         r_carry <= 1'b0;
      end else if (load) begin
         r_count <= data;
         r_carry <= 1'b0;
      end else if (enable) begin
         if (up_down)
            {r_carry, r_count} <= {1'b0, r_count} - (n+1)'(1);
         else
            {r_carry, r_count} <= {1'b0, r_count} + (n+1)'(1);
      end else begin
         r_carry <= 1'b0;
      end
   end

   assign count     = r_count;
   assign carry_out = r_carry;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller sequencing the up/down counter: one-shot/periodic ticks with abort.
// Optional pause input enabled by defining INTERVAL_TIMER_PAUSE_EN.
module interval_timer_ctrl
   import interval_timer_ctrl_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         sclr,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic [N-1:0] period,
`ifdef INTERVAL_TIMER_PAUSE_EN
   input  logic         pause,
`endif
   output logic         busy,
   output logic         tick,
   output logic         done,
   output logic [N-1:0] count
);

   tmr_state_e   r_state;
   logic [N-1:0] r_period;
   logic         r_mode;
   logic         r_busy;
   logic         r_tick;
   logic         r_done;

   logic         w_pause;
   logic         w_active;
   logic         w_expire;
   logic         w_ctr_sclr;
   logic         w_ctr_load;
   logic         w_ctr_en;
   logic [N-1:0] w_reload;
   logic         w_carry_unused;

`ifdef INTERVAL_TIMER_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   // Stop beats expiry and pause freezes expiry evaluation, so both gate w_expire.
   assign w_active   = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign w_expire   = (r_state == ST_RUN) && (count == '0) && !stop && !w_pause;
   assign w_reload   = r_period - N'(1);
   assign w_ctr_sclr = sclr || (stop && w_active);
   assign w_ctr_load = ((r_state == ST_LOAD) && !stop) ||
                       (w_expire && (r_mode == TMR_PERIODIC));
   assign w_ctr_en   = (r_state == ST_RUN) && (count != '0) && !stop && !w_pause;

   interval_timer_ctrl_counter #(
      .n (N)
   ) u_counter (
      .clk       (clk),
      .sclr      (w_ctr_sclr),
      .load      (w_ctr_load),
      .enable    (w_ctr_en),
      .up_down   (1'b1),
      .data      (w_reload),
      .count     (count),
      .carry_out (w_carry_unused)
   );

   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state  <= ST_IDLE;
         r_period <= '0;
         r_mode   <= TMR_ONESHOT;
         r_busy   <= 1'b0;
         r_tick   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !stop && (period != '0)) begin
                  r_period <= period;
                  r_mode   <= periodic;
                  r_done   <= 1'b0;
                  r_state  <= ST_LOAD;
                  r_busy   <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_expire) begin
                  r_tick <= 1'b1;
                  if (r_mode == TMR_ONESHOT) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign tick = r_tick;
   assign done = r_done;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: one-shot, periodic, stop, sclr and corner start commands.
module tb_interval_timer_ctrl;

   logic       clk = 1'b0;
   logic       sclr;
   logic       start;
   logic       stop;
   logic       periodic;
   logic [7:0] period;
   logic       pause;
   logic       busy;
   logic       tick;
   logic       done;
   logic [7:0] count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   interval_timer_ctrl #(.N(8)) dut (
      .clk      (clk),
      .sclr     (sclr),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .period   (period),
`ifdef INTERVAL_TIMER_PAUSE_EN
      .pause    (pause),
`endif
      .busy     (busy),
      .tick     (tick),
      .done     (done),
      .count    (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_timer(input logic [7:0] p, input logic mode);
      period   = p;
      periodic = mode;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   initial begin
      sclr = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; period = 8'd0; pause = 1'b0;
      step();
      step();
      chk("reset_busy", 32'(busy), 0);
      chk("reset_tick", 32'(tick), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_count", 32'(count), 0);
      sclr = 1'b0;

      // One-shot P=5: counts 4..0 after edges 1..5, tick/done after edge 6
      start_timer(8'd5, 1'b0);
      chk("os_busy_e0", 32'(busy), 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("os_count", 32'(count), 32'(5 - k));
         chk("os_tick_early", 32'(tick), 0);
      end
      step();
      chk("os_tick", 32'(tick), 1);
      chk("os_done", 32'(done), 1);
      chk("os_busy_end", 32'(busy), 0);
      chk("os_count_end", 32'(count), 0);
      step();
      chk("os_tick_one_cycle", 32'(tick), 0);
      chk("os_done_sticky", 32'(done), 1);

      // Periodic P=3: ticks after edges 4,7,10,13
      start_timer(8'd3, 1'b1);
      chk("per_done_cleared", 32'(done), 0);
      for (int e = 1; e <= 13; e++) begin
         step();
         chk("per_count", 32'(count), 32'(2 - ((e - 1) % 3)));
         chk("per_tick", 32'(tick), ((e >= 4) && (((e - 4) % 3) == 0)) ? 32'd1 : 32'd0);
      end
      chk("per_done", 32'(done), 0);
      chk("per_busy", 32'(busy), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("per_stop_busy", 32'(busy), 0);
      chk("per_stop_count", 32'(count), 0);

      // Stop at count==2, P=6
      start_timer(8'd6, 1'b0);
      step(); step(); step(); step();
      chk("stop_pre_count", 32'(count), 2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      chk("stop_count", 32'(count), 0);
      chk("stop_tick", 32'(tick), 0);
      chk("stop_done", 32'(done), 0);
      step();
      chk("stop_tick_after", 32'(tick), 0);

      // Start with period 0 is ignored
      start_timer(8'd0, 1'b0);
      chk("p0_busy", 32'(busy), 0);
      step();
      chk("p0_busy_later", 32'(busy), 0);
      chk("p0_count", 32'(count), 0);

      // Start together with stop is ignored
      stop = 1'b1;
      start_timer(8'd5, 1'b0);
      stop = 1'b0;
      chk("startstop_busy", 32'(busy), 0);
      step();
      chk("startstop_count", 32'(count), 0);

      // Start while running with new period 9 and periodic=1 is ignored
      start_timer(8'd5, 1'b0);
      step();
      period = 8'd9; periodic = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_start_count_e2", 32'(count), 3);
      step(); step(); step();
      chk("busy_start_count_e5", 32'(count), 0);
      chk("busy_start_tick_e5", 32'(tick), 0);
      step();
      chk("busy_start_tick", 32'(tick), 1);
      chk("busy_start_done", 32'(done), 1);
      chk("busy_start_idle", 32'(busy), 0);
      periodic = 1'b0;

      // sclr mid-RUN at count 4, P=10
      start_timer(8'd10, 1'b0);
      for (int k = 1; k <= 6; k++) step();
      chk("sclr_pre_count", 32'(count), 4);
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      chk("sclr_busy", 32'(busy), 0);
      chk("sclr_count", 32'(count), 0);
      chk("sclr_tick", 32'(tick), 0);
      chk("sclr_done", 32'(done), 0);

      // Stop coinciding with expiry, P=3
      start_timer(8'd3, 1'b0);
      step(); step(); step();
      chk("stopexp_pre_count", 32'(count), 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stopexp_tick", 32'(tick), 0);
      chk("stopexp_done", 32'(done), 0);
      chk("stopexp_busy", 32'(busy), 0);
      step();
      chk("stopexp_tick_after", 32'(tick), 0);

      // Periodic P=1: tick every cycle from edge 2
      start_timer(8'd1, 1'b1);
      step();
      chk("p1_tick_e1", 32'(tick), 0);
      chk("p1_count_e1", 32'(count), 0);
      step();
      chk("p1_tick_e2", 32'(tick), 1);
      step();
      chk("p1_tick_e3", 32'(tick), 1);
      step();
      chk("p1_tick_e4", 32'(tick), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("p1_stop_busy", 32'(busy), 0);
      periodic = 1'b0;

`ifdef INTERVAL_TIMER_PAUSE_EN
      // P=4 one-shot, pause 3 cycles at count 2: tick moves from edge 5 to edge 8
      start_timer(8'd4, 1'b0);
      step(); step();
      chk("pause_pre_count", 32'(count), 2);
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("pause_hold", 32'(count), 2);
         chk("pause_no_tick", 32'(tick), 0);
      end
      pause = 1'b0;
      step();
      chk("pause_count_e6", 32'(count), 1);
      step();
      chk("pause_count_e7", 32'(count), 0);
      chk("pause_tick_e7", 32'(tick), 0);
      step();
      chk("pause_tick_e8", 32'(tick), 1);
      chk("pause_done", 32'(done), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
